// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline hazard/stall control bus: ID/EX hazard inputs in, register enables,
// flush controls and performance counters out.
interface hazard_stall_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       ID_Rs;
    logic [4:0]       ID_Rt;
    logic             ID_UsesRt;
    logic             ID_IsMul;
    logic             EX_MemRead;
    logic [4:0]       EX_Rt;
    logic             EX_Redirect;
    logic             PCWrite;
    logic             IF_ID_Write;
    logic             IF_ID_Flush;
    logic             ID_EX_Write;
    logic             ID_EX_Flush;
    logic             EX_MEM_Bubble;
    logic [CNT_W-1:0] StallCycles;
    logic [CNT_W-1:0] FlushEvents;

    modport master (
        output ID_Rs, ID_Rt, ID_UsesRt, ID_IsMul, EX_MemRead, EX_Rt, EX_Redirect,
        input  PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush, EX_MEM_Bubble,
        input  StallCycles, FlushEvents
    );

    modport slave (
        input  ID_Rs, ID_Rt, ID_UsesRt, ID_IsMul, EX_MemRead, EX_Rt, EX_Redirect,
        output PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush, EX_MEM_Bubble,
        output StallCycles, FlushEvents
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencer: load-use stalls, multi-cycle multiply hold in EX, and
// wrong-path flush on EX redirect, with saturating stall/flush counters.
module hazard_stall_ctrl #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int MUL_LAT           = 4,
    parameter int CNT_W             = 16
) (
    input logic                Clk,
    input logic                Rst_n,
    hazard_stall_ctrl_if.slave bus
);
    localparam int CNT_MAX = (LOAD_STALL_CYCLES > MUL_LAT) ? LOAD_STALL_CYCLES : MUL_LAT;
    localparam int CW      = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
    localparam logic [CW-1:0] LS_INIT  = CW'((LOAD_STALL_CYCLES > 1) ? LOAD_STALL_CYCLES - 2 : 0);
    localparam logic [CW-1:0] MUL_INIT = CW'(MUL_LAT - 2);

    typedef enum logic [1:0] {RUN, LOAD_STALL, MUL_BUSY} state_t;

    state_t           state, stateNxt;
    logic [CW-1:0]    cnt, cntNxt;
    logic [CNT_W-1:0] stallCycles, flushEvents;
    logic             loadUse, flushAccept;
    logic             pcWrite, ifIdWrite, ifIdFlush, idExWrite, idExFlush, exMemBubble;

    // A load into r0 never creates a dependency.
    assign loadUse = bus.EX_MemRead && (bus.EX_Rt != 5'd0) &&
                     ((bus.EX_Rt == bus.ID_Rs) || (bus.ID_UsesRt && (bus.EX_Rt == bus.ID_Rt)));
    assign flushAccept = bus.EX_Redirect && (state != MUL_BUSY);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state       <= RUN;
            cnt         <= '0;
            stallCycles <= '0;
            flushEvents <= '0;
        end else begin
            state <= stateNxt;
            cnt   <= cntNxt;
            if (!pcWrite && (stallCycles != '1))
                stallCycles <= stallCycles + 1'b1;
            if (flushAccept && (flushEvents != '1))
                flushEvents <= flushEvents + 1'b1;
        end
    end

    always_comb begin
        stateNxt = state;
        cntNxt   = cnt;
        case (state)
            RUN: begin
                if (!bus.EX_Redirect) begin
                    if (loadUse) begin
                        if (LOAD_STALL_CYCLES > 1) begin
                            stateNxt = LOAD_STALL;
                            cntNxt   = LS_INIT;
                        end
                    end else if (bus.ID_IsMul) begin
                        stateNxt = MUL_BUSY;
                        cntNxt   = MUL_INIT;
                    end
                end
            end
            LOAD_STALL: begin
                if (bus.EX_Redirect || (cnt == '0)) begin
                    stateNxt = RUN;
                    cntNxt   = '0;
                end else begin
                    cntNxt = cnt - 1'b1;
                end
            end
            MUL_BUSY: begin
                if (cnt == '0) stateNxt = RUN;
                else           cntNxt   = cnt - 1'b1;
            end
            default: begin
                stateNxt = RUN;
                cntNxt   = '0;
            end
        endcase
    end

    always_comb begin
        pcWrite     = 1'b1;
        ifIdWrite   = 1'b1;
        ifIdFlush   = 1'b0;
        idExWrite   = 1'b1;
        idExFlush   = 1'b0;
        exMemBubble = 1'b0;
        if (!Rst_n) begin
            pcWrite     = 1'b0;
            ifIdWrite   = 1'b0;
            ifIdFlush   = 1'b1;
            idExFlush   = 1'b1;
            exMemBubble = 1'b1;
        end else begin
            case (state)
                RUN, LOAD_STALL: begin
                    if (bus.EX_Redirect) begin
                        ifIdFlush = 1'b1;
                        idExFlush = 1'b1;
                    end else if (loadUse || (state == LOAD_STALL)) begin
                        pcWrite   = 1'b0;
                        ifIdWrite = 1'b0;
                        idExFlush = 1'b1;
                    end
                end
                MUL_BUSY: begin
                    pcWrite     = 1'b0;
                    ifIdWrite   = 1'b0;
                    idExWrite   = 1'b0;
                    exMemBubble = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.PCWrite       = pcWrite;
    assign bus.IF_ID_Write   = ifIdWrite;
    assign bus.IF_ID_Flush   = ifIdFlush;
    assign bus.ID_EX_Write   = idExWrite;
    assign bus.ID_EX_Flush   = idExFlush;
    assign bus.EX_MEM_Bubble = exMemBubble;
    assign bus.StallCycles   = stallCycles;
    assign bus.FlushEvents   = flushEvents;
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: a vector table on the default build plus
// hand sequences for multi-cycle load stalls, reset abort and counter saturation.
module tb_hazard_stall_ctrl;
    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       usesRt;
        logic       isMul;
        logic       memRead;
        logic [4:0] exRt;
        logic       redirect;
    } stim_t;

    typedef struct {
        stim_t      stim;
        logic [5:0] expOut;
        int         expStall;
        int         expFlush;
    } vec_t;

    // {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush, EX_MEM_Bubble}
    localparam logic [5:0] DEF = 6'b110100;
    localparam logic [5:0] STL = 6'b000110;
    localparam logic [5:0] RED = 6'b111110;
    localparam logic [5:0] MUL = 6'b000001;
    localparam logic [5:0] RST = 6'b001111;

    logic  Clk;
    logic  Rst_n;
    stim_t i0, i1, i2;
    logic [5:0] o0, o1, o2;
    int    nChecks = 0;
    int    nPass   = 0;
    vec_t  vec [15];

    hazard_stall_ctrl_if #(.CNT_W(16)) b0 ();
    hazard_stall_ctrl_if #(.CNT_W(16)) b1 ();
    hazard_stall_ctrl_if #(.CNT_W(4))  b2 ();

    hazard_stall_ctrl #(.LOAD_STALL_CYCLES(1), .MUL_LAT(4), .CNT_W(16)) u0 (.Clk(Clk), .Rst_n(Rst_n), .bus(b0));
    hazard_stall_ctrl #(.LOAD_STALL_CYCLES(3), .MUL_LAT(4), .CNT_W(16)) u1 (.Clk(Clk), .Rst_n(Rst_n), .bus(b1));
    hazard_stall_ctrl #(.LOAD_STALL_CYCLES(1), .MUL_LAT(4), .CNT_W(4))  u2 (.Clk(Clk), .Rst_n(Rst_n), .bus(b2));

    assign b0.ID_Rs = i0.rs;  assign b0.ID_Rt = i0.rt;  assign b0.ID_UsesRt = i0.usesRt;
    assign b0.ID_IsMul = i0.isMul;  assign b0.EX_MemRead = i0.memRead;
    assign b0.EX_Rt = i0.exRt;  assign b0.EX_Redirect = i0.redirect;
    assign b1.ID_Rs = i1.rs;  assign b1.ID_Rt = i1.rt;  assign b1.ID_UsesRt = i1.usesRt;
    assign b1.ID_IsMul = i1.isMul;  assign b1.EX_MemRead = i1.memRead;
    assign b1.EX_Rt = i1.exRt;  assign b1.EX_Redirect = i1.redirect;
    assign b2.ID_Rs = i2.rs;  assign b2.ID_Rt = i2.rt;  assign b2.ID_UsesRt = i2.usesRt;
    assign b2.ID_IsMul = i2.isMul;  assign b2.EX_MemRead = i2.memRead;
    assign b2.EX_Rt = i2.exRt;  assign b2.EX_Redirect = i2.redirect;

    assign o0 = {b0.PCWrite, b0.IF_ID_Write, b0.IF_ID_Flush, b0.ID_EX_Write, b0.ID_EX_Flush, b0.EX_MEM_Bubble};
    assign o1 = {b1.PCWrite, b1.IF_ID_Write, b1.IF_ID_Flush, b1.ID_EX_Write, b1.ID_EX_Flush, b1.EX_MEM_Bubble};
    assign o2 = {b2.PCWrite, b2.IF_ID_Write, b2.IF_ID_Flush, b2.ID_EX_Write, b2.ID_EX_Flush, b2.EX_MEM_Bubble};

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // A multiply occupies EX while the bubble is driven; no redirect may resolve then.
    always @(posedge Clk)
        if (Rst_n) assert (!(b0.EX_MEM_Bubble && b0.EX_Redirect));

    function automatic stim_t mk(input int rs, input int rt, input bit usesRt, input bit isMul,
                                 input bit memRead, input int exRt, input bit redirect);
        stim_t s;
        s.rs = 5'(rs);  s.rt = 5'(rt);  s.usesRt = usesRt;  s.isMul = isMul;
        s.memRead = memRead;  s.exRt = 5'(exRt);  s.redirect = redirect;
        return s;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    initial begin
        stim_t idle, lu5;
        idle = mk(1, 2, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        lu5  = mk(5, 2, 1'b0, 1'b0, 1'b1, 5, 1'b0);

        vec[0]  = '{idle,                                  DEF, 0, 0};
        vec[1]  = '{lu5,                                   STL, 1, 0};
        vec[2]  = '{idle,                                  DEF, 1, 0};
        vec[3]  = '{mk(3, 5, 1'b0, 1'b0, 1'b1, 5, 1'b0),   DEF, 1, 0};
        vec[4]  = '{mk(3, 5, 1'b1, 1'b0, 1'b1, 5, 1'b0),   STL, 2, 0};
        vec[5]  = '{mk(0, 0, 1'b1, 1'b0, 1'b1, 0, 1'b0),   DEF, 2, 0};
        vec[6]  = '{mk(7, 2, 1'b0, 1'b0, 1'b1, 7, 1'b1),   RED, 2, 1};
        vec[7]  = '{mk(1, 2, 1'b1, 1'b1, 1'b0, 0, 1'b0),   DEF, 2, 1};
        vec[8]  = '{lu5,                                   MUL, 3, 1};
        vec[9]  = '{idle,                                  MUL, 4, 1};
        vec[10] = '{idle,                                  MUL, 5, 1};
        vec[11] = '{idle,                                  DEF, 5, 1};
        vec[12] = '{mk(5, 2, 1'b0, 1'b1, 1'b1, 5, 1'b0),   STL, 6, 1};
        vec[13] = '{idle,                                  DEF, 6, 1};
        vec[14] = '{mk(1, 2, 1'b0, 1'b0, 1'b0, 0, 1'b1),   RED, 6, 2};

        Rst_n = 1'b0;
        i0 = idle;  i1 = idle;  i2 = idle;
        #2;
        chk("rst_out0", o0, RST);
        chk("rst_out1", o1, RST);
        chk("rst_out2", o2, RST);
        chk("rst_stall0", b0.StallCycles, 0);
        chk("rst_flush0", b0.FlushEvents, 0);
        @(negedge Clk);
        Rst_n = 1'b1;

        for (int k = 0; k < 15; k++) begin
            i0 = vec[k].stim;
            #2;
            chk($sformatf("v%0d_out", k), o0, vec[k].expOut);
            @(posedge Clk); #1;
            chk($sformatf("v%0d_stall", k), b0.StallCycles, vec[k].expStall);
            chk($sformatf("v%0d_flush", k), b0.FlushEvents, vec[k].expFlush);
            @(negedge Clk);
        end
        i0 = idle;

        // Three-cycle load stall from a single hazard cycle.
        i1 = lu5;  #2;  chk("ls3_c1", o1, STL);
        @(negedge Clk);  i1 = idle;  #2;  chk("ls3_c2", o1, STL);
        @(negedge Clk);  #2;  chk("ls3_c3", o1, STL);
        @(negedge Clk);  #2;  chk("ls3_run", o1, DEF);
        chk("ls3_stall", b1.StallCycles, 3);

        // Redirect during a load stall wins and returns to RUN.
        @(negedge Clk);  i1 = lu5;  #2;  chk("lsred_c1", o1, STL);
        @(negedge Clk);  i1 = mk(1, 2, 1'b0, 1'b0, 1'b0, 0, 1'b1);  #2;  chk("lsred_red", o1, RED);
        @(negedge Clk);  i1 = idle;  #2;  chk("lsred_run", o1, DEF);
        chk("lsred_flush", b1.FlushEvents, 1);
        chk("lsred_stall", b1.StallCycles, 4);

        // Reset dropped on the second stall cycle aborts the stall.
        @(negedge Clk);  i1 = lu5;  #2;  chk("rsab_c1", o1, STL);
        @(negedge Clk);  i1 = idle;  #2;  chk("rsab_c2", o1, STL);
        Rst_n = 1'b0;  #1;
        chk("rsab_out", o1, RST);
        chk("rsab_stall", b1.StallCycles, 0);
        chk("rsab_flush", b1.FlushEvents, 0);
        @(negedge Clk);  Rst_n = 1'b1;  #2;
        chk("rsab_run", o1, DEF);
        @(posedge Clk); #1;
        chk("rsab_nostall", b1.StallCycles, 0);

        // Narrow counters saturate instead of wrapping.
        @(negedge Clk);  i2 = lu5;
        for (int n = 1; n <= 20; n++) begin
            @(posedge Clk); #1;
            if (n == 14) chk("sat_stall14", b2.StallCycles, 14);
        end
        chk("sat_out", o2, STL);
        chk("sat_stall", b2.StallCycles, 15);
        @(negedge Clk);  i2 = mk(1, 2, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        repeat (17) @(posedge Clk);
        #1;
        chk("sat_flush", b2.FlushEvents, 15);
        chk("sat_stall_hold", b2.StallCycles, 15);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
